// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner.
//   scan_state_e : row-scan FSM states
//   width_of()   : bits needed to index n values (never less than 1)
//   event_width(): width of one event record {logical key, pressed}
package keypad_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EMIT   = 3'd4
  } scan_state_e;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int event_width(input int iw);
    return iw + 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_event_fifo.sv
// Synchronous event FIFO for the keypad scanner.
//   clock, reset      : system clock, asynchronous active-low reset
//   push, push_data   : write request and record
//   pop               : consumer takes the head record
//   pop_data          : head record, read straight from the storage registers
//   full, empty       : occupancy flags
// A push while full is only accepted when a pop frees a slot in the same cycle.
module event_fifo
  import keypad_scanner_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = width_of(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning, debounced, remappable keypad matrix driver.
//   clock, reset        : system clock, asynchronous active-low reset
//   keymap              : slice p = logical index of physical key p (row*COLS+col)
//   keypad_column       : raw active-low column sense lines
//   released_keys_clear : clears the sticky release bitmap
//   event_ready         : consumer handshake
//   keypad_row          : one-cold row drive (all ones while idle after reset)
//   keypad_out          : debounced level per logical key
//   released_keys_out   : sticky release flag per logical key
//   event_valid/key/pressed : press/release event stream
//   event_overflow      : sticky, an event was dropped on a full FIFO
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int MAIN_FREQUENCY = 6281250,
  parameter int POLL_FREQUENCY = 100,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int EVENT_DEPTH    = 8
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [ROWS*COLS*$clog2(ROWS*COLS)-1:0]    keymap,
  input  logic [COLS-1:0]                           keypad_column,
  input  logic                                      released_keys_clear,
  input  logic                                      event_ready,
  output logic [ROWS-1:0]                           keypad_row,
  output logic [ROWS*COLS-1:0]                      keypad_out,
  output logic [ROWS*COLS-1:0]                      released_keys_out,
  output logic                                      event_valid,
  output logic [$clog2(ROWS*COLS)-1:0]              event_key,
  output logic                                      event_pressed,
  output logic                                      event_overflow
);

  localparam int K    = ROWS * COLS;
  localparam int IW   = $clog2(K);
  localparam int TICK = MAIN_FREQUENCY / (POLL_FREQUENCY * ROWS);
  localparam int RW   = width_of(ROWS);
  localparam int CLW  = width_of(COLS);
  localparam int PW   = width_of(K);
  localparam int TW   = width_of(TICK);
  localparam int SW   = width_of(SETTLE_CYCLES);
  localparam int DW   = width_of(DEBOUNCE_SCANS);
  localparam int EW   = event_width(IW);

  // One row visit (drive, settle, sample, emit) must fit inside one tick.
  if (TICK <= SETTLE_CYCLES + COLS + 4) begin : g_bad_tick
    $error("keypad_scanner: TICK too small for a full row visit");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_SCANS must be at least 1");
  end
  if ((EVENT_DEPTH & (EVENT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_scanner: EVENT_DEPTH must be a power of two");
  end

  scan_state_e     state_q, state_d;
  logic [TW-1:0]   presc_q, presc_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [COLS-1:0] row_raw_q, row_raw_d;
  logic [COLS-1:0] col_meta_q, col_meta_d;
  logic [COLS-1:0] col_sync_q, col_sync_d;
  logic [ROWS-1:0] keypad_row_q, keypad_row_d;
  logic [K-1:0]    stable_q, stable_d;
  logic [DW-1:0]   cnt_q [K];
  logic [DW-1:0]   cnt_d [K];
  logic [K-1:0]    keypad_out_q, keypad_out_d;
  logic [K-1:0]    released_q, released_d;
  logic            overflow_q, overflow_d;

  logic [PW-1:0]   phys;
  logic [IW-1:0]   lkey;
  logic            raw;
  logic            tick;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_dout;

  assign phys = PW'(int'(row_q) * COLS + int'(col_q));
  assign lkey = keymap[int'(phys)*IW +: IW];
  assign raw  = row_raw_q[col_q];
  assign tick = (presc_q == TW'(TICK - 1));
  assign pop  = event_valid && event_ready;

  always_comb begin
    state_d      = state_q;
    presc_d      = tick ? '0 : presc_q + TW'(1);
    row_d        = row_q;
    settle_d     = settle_q;
    col_d        = col_q;
    row_raw_d    = row_raw_q;
    col_meta_d   = keypad_column;
    col_sync_d   = col_meta_q;
    keypad_row_d = keypad_row_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    keypad_out_d = keypad_out_q;
    // A release flip in this same cycle re-sets its bit after the clear.
    released_d   = released_keys_clear ? '0 : released_q;
    overflow_d   = overflow_q;
    push         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        row_d        = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        keypad_row_d = ~(ROWS'(1) << row_d);
        settle_d     = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The two synchronizer stages are covered by this wait.
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
        else                                   settle_d = settle_q + SW'(1);
      end
      ST_SAMPLE: begin
        row_raw_d = ~col_sync_q;
        col_d     = '0;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        if (raw == stable_q[phys]) begin
          cnt_d[phys] = '0;
        end else if (cnt_q[phys] == DW'(DEBOUNCE_SCANS - 1)) begin
          stable_d[phys]     = raw;
          cnt_d[phys]        = '0;
          keypad_out_d[lkey] = raw;
          if (!raw) released_d[lkey] = 1'b1;
          push = 1'b1;
        end else begin
          cnt_d[phys] = cnt_q[phys] + DW'(1);
        end
        if (col_q == CLW'(COLS - 1)) state_d = ST_IDLE;
        else                         col_d   = col_q + CLW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A simultaneous pop frees a slot, so only a stalled full FIFO drops.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      row_q        <= RW'(ROWS - 1);
      settle_q     <= '0;
      col_q        <= '0;
      row_raw_q    <= '0;
      col_meta_q   <= '1;
      col_sync_q   <= '1;
      keypad_row_q <= '1;
      stable_q     <= '0;
      for (int i = 0; i < K; i++) cnt_q[i] <= '0;
      keypad_out_q <= '0;
      released_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      col_q        <= col_d;
      row_raw_q    <= row_raw_d;
      col_meta_q   <= col_meta_d;
      col_sync_q   <= col_sync_d;
      keypad_row_q <= keypad_row_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      keypad_out_q <= keypad_out_d;
      released_q   <= released_d;
      overflow_q   <= overflow_d;
    end
  end

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (EVENT_DEPTH)
  ) u_event_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({lkey, raw}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign keypad_row        = keypad_row_q;
  assign keypad_out        = keypad_out_q;
  assign released_keys_out = released_q;
  assign event_valid       = !fifo_empty;
  assign event_key         = fifo_dout[EW-1:1];
  assign event_pressed     = fifo_dout[0];
  assign event_overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int K     = 16;
  localparam int IW    = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [K*IW-1:0]   keymap;
  logic [COLS-1:0]   keypad_column;
  logic              released_keys_clear = 1'b0;
  logic              event_ready = 1'b1;
  logic [ROWS-1:0]   keypad_row;
  logic [K-1:0]      keypad_out;
  logic [K-1:0]      released_keys_out;
  logic              event_valid;
  logic [IW-1:0]     event_key;
  logic              event_pressed;
  logic              event_overflow;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .MAIN_FREQUENCY(12800), .POLL_FREQUENCY(100),
    .SETTLE_CYCLES(16), .DEBOUNCE_SCANS(DEB), .EVENT_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .keymap(keymap), .keypad_column(keypad_column),
    .released_keys_clear(released_keys_clear), .event_ready(event_ready),
    .keypad_row(keypad_row), .keypad_out(keypad_out),
    .released_keys_out(released_keys_out), .event_valid(event_valid),
    .event_key(event_key), .event_pressed(event_pressed),
    .event_overflow(event_overflow)
  );

  always #5 clock = ~clock;

  // Physical matrix: a held key pulls its column low while its row is driven.
  logic [K-1:0] key_down = '0;
  always_comb begin
    keypad_column = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!keypad_row[r] && key_down[r*COLS+c]) keypad_column[c] = 1'b0;
  end

  logic [4:0] got_q[$];
  always @(negedge clock)
    if (reset && event_valid && event_ready) got_q.push_back({event_key, event_pressed});

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model, one whole matrix scan at a time.
  logic [K-1:0] m_stable, m_out, m_rel;
  int           m_run [K];
  logic         m_ovf;
  logic [4:0]   exp_q[$];
  logic         cur_rdy;

  logic [K*IW-1:0] id_map, map;
  logic [K-1:0]    keys, intent;
  logic            rdy;
  bit              seen;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_stable = '0; m_out = '0; m_rel = '0; m_ovf = 1'b0;
    for (int p = 0; p < K; p++) m_run[p] = 0;
    exp_q.delete();
  endtask

  task automatic model_scan(input logic [K-1:0] k, input logic [K*IW-1:0] mp,
                            input int clr_p, input logic r);
    logic [IW-1:0] l;
    for (int p = 0; p < K; p++) begin
      l = mp[p*IW +: IW];
      if (clr_p == p) m_rel = '0;
      m_run[p] = (k[p] != m_stable[p]) ? m_run[p] + 1 : 0;
      if (m_run[p] == DEB) begin
        m_run[p]    = 0;
        m_stable[p] = k[p];
        m_out[l]    = k[p];
        if (!k[p]) m_rel[l] = 1'b1;
        if (r || exp_q.size() < DEPTH) exp_q.push_back({l, k[p]});
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Waits for keypad_row to switch to the given pattern (bounded).
  task automatic wait_row(input logic [ROWS-1:0] pattern);
    logic [ROWS-1:0] prev;
    bit found;
    found = 0;
    prev = keypad_row;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clock); #1;
      if (keypad_row == pattern && prev != pattern) found = 1;
      prev = keypad_row;
    end
    chk("row_wait", 32'(found), 32'd1);
  endtask

  task automatic check_state(input string tag);
    int n_exp;
    n_exp = cur_rdy ? exp_q.size() : 0;
    chk({tag, "_evt_count"}, got_q.size(), n_exp);
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++)
      chk({tag, "_evt"}, 32'(got_q[i]), 32'(exp_q.pop_front()));
    got_q.delete();
    chk({tag, "_keypad_out"}, 32'(keypad_out), 32'(m_out));
    chk({tag, "_released"}, 32'(released_keys_out), 32'(m_rel));
    chk({tag, "_overflow"}, 32'(event_overflow), 32'(m_ovf));
    chk({tag, "_valid"}, 32'(event_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, "_head"}, 32'({event_key, event_pressed}), 32'(exp_q[0]));
  endtask

  // Called at the start of a scan (row 0 just driven); returns at the next one.
  task automatic do_scan(input logic [K-1:0] k, input logic [K*IW-1:0] mp,
                         input int clr_p, input logic r, input string tag);
    key_down = k; keymap = mp; event_ready = r; cur_rdy = r;
    if (clr_p >= 0) begin
      if (clr_p / COLS != 0) wait_row(~(4'b0001 << (clr_p / COLS)));
      // Drive to sample takes 1 + 16 settle + 1 sample cycles; col c emits c cycles later.
      repeat (17 + clr_p % COLS) begin @(posedge clock); #1; end
      released_keys_clear = 1'b1;
      @(posedge clock); #1;
      released_keys_clear = 1'b0;
    end
    model_scan(k, mp, clr_p, r);
    wait_row(4'b1110);
    check_state(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_row"}, 32'(keypad_row), 32'hF);
    chk({tag, "_out"}, 32'(keypad_out), 32'h0);
    chk({tag, "_rel"}, 32'(released_keys_out), 32'h0);
    chk({tag, "_valid"}, 32'(event_valid), 32'h0);
    chk({tag, "_ovf"}, 32'(event_overflow), 32'h0);
  endtask

  task automatic first_drive();
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock); #1;
      if (keypad_row != 4'hF) seen = 1;
    end
    chk("first_drive_row", 32'(keypad_row), 32'hE);
  endtask

  initial begin
    for (int p = 0; p < K; p++) id_map[p*IW +: IW] = 4'(p);
    keymap = id_map;
    cur_rdy = 1'b1;
    model_reset();

    // Power-on reset
    #2 reset = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    first_drive();

    // Debounced press of physical key 5, then its release
    do_scan(16'h0020, id_map, -1, 1'b1, "press1");
    do_scan(16'h0020, id_map, -1, 1'b1, "press2");
    chk("press_not_yet", 32'(keypad_out), 32'h0);
    do_scan(16'h0020, id_map, -1, 1'b1, "press3");
    chk("press_bitmap", 32'(keypad_out), 32'h0020);
    repeat (3) do_scan(16'h0000, id_map, -1, 1'b1, "release");
    chk("release_bitmap", 32'(released_keys_out), 32'h0020);

    // Bounce: two low samples then high
    do_scan(16'h0020, id_map, -1, 1'b1, "bounce");
    do_scan(16'h0020, id_map, -1, 1'b1, "bounce");
    do_scan(16'h0000, id_map, -1, 1'b1, "bounce");
    do_scan(16'h0000, id_map, -1, 1'b1, "bounce");
    chk("bounce_bitmap", 32'(keypad_out), 32'h0);

    // Remap physical 5 to logical 10
    map = id_map;
    map[5*IW +: IW] = 4'hA;
    repeat (3) do_scan(16'h0020, map, -1, 1'b1, "remap_press");
    chk("remap_press", 32'(keypad_out), 32'h0400);
    repeat (3) do_scan(16'h0000, map, -1, 1'b1, "remap_rel");
    chk("remap_rel", 32'(released_keys_out), 32'h0420);

    // Overflow: nine changes with the consumer stalled
    repeat (3) do_scan(16'h01FF, id_map, -1, 1'b0, "ovf_stall");
    chk("ovf_flag", 32'(event_overflow), 32'h1);
    do_scan(16'h01FF, id_map, -1, 1'b1, "ovf_drain");

    // Reset in the middle of SETTLE on row 1
    wait_row(4'b1101);
    repeat (5) begin @(posedge clock); #1; end
    #2 reset = 1'b0;
    #1 check_reset_values("mid_reset");
    key_down = '0;
    model_reset();
    got_q.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    first_drive();

    // Clear coinciding with the release of key 4
    repeat (3) do_scan(16'h0013, id_map, -1, 1'b1, "coll_press");
    repeat (3) do_scan(16'h0010, id_map, -1, 1'b1, "coll_rel01");
    chk("coll_pre", 32'(released_keys_out), 32'h0003);
    do_scan(16'h0000, id_map, -1, 1'b1, "coll_rel4");
    do_scan(16'h0000, id_map, -1, 1'b1, "coll_rel4");
    do_scan(16'h0000, id_map, 4, 1'b1, "coll_clear");
    chk("coll_result", 32'(released_keys_out), 32'h0010);

    // Random key activity, keymaps and consumer stalls
    intent = '0;
    map = id_map;
    for (int s = 0; s < 40; s++) begin
      for (int p = 0; p < K; p++)
        if ($urandom_range(0, 7) == 0) intent[p] = ~intent[p];
      keys = intent;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] ^= 1'b1;
      if (s % 8 == 0)
        for (int p = 0; p < K; p++) map[p*IW +: IW] = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      do_scan(keys, map, -1, rdy, "rand");
    end
    do_scan(keys, map, -1, 1'b1, "rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
